// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: STAT/RX/TX register window, buffered TX and RX, 1-cycle response.
// Requests accepted every cycle; TX writes to a full FIFO and RX bytes into a full FIFO are dropped.
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_dat;
  end
endmodule

module uart_mmio #(
  parameter int CLKDIV     = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_wmask,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int CW = $clog2(CLKDIV + 1);
  localparam logic [CW-1:0] BIT_LEN  = CW'(CLKDIV);
  localparam logic [CW-1:0] HALF_LEN = CW'(CLKDIV / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic        unused_bits;
  logic        rd, tx_wr, rx_rd;
  logic [31:0] rdata_d, stat;
  logic        tx_full, tx_empty, tx_pop;
  logic [7:0]  tx_head, tx_shift;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0]  tx_bit, rx_bit;
  state_t      tx_state, tx_next, rx_state, rx_next;
  logic        rx_full, rx_empty, rx_push, rx_meta, rx_s;
  logic [7:0]  rx_head, rx_shift;
  logic        tx_exp, rx_exp;

  assign unused_bits = ^{req_wdata[31:8], req_wmask[3:1]};

  assign rd    = req_valid && !req_we;
  assign tx_wr = req_valid && req_we && (req_addr == 2'd2) && req_wmask[0];
  assign rx_rd = rd && (req_addr == 2'd1) && !rx_empty;
  assign stat  = {28'b0, tx_full, tx_empty && (tx_state == IDLE), rx_full, rx_empty};

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      case (req_addr)
        2'd0:    rdata_d = stat;
        2'd1:    rdata_d = rx_empty ? 32'b0 : {24'b0, rx_head};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= req_valid;
      resp_rdata <= rdata_d;
    end
  end

  uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_wr), .push_dat(req_wdata[7:0]),
    .pop(tx_pop), .pop_dat(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .push_dat(rx_shift),
    .pop(rx_rd), .pop_dat(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // Bit counters reload with the bit length and expire at 1.
  assign tx_exp = (tx_cnt == CNT_ONE);
  assign rx_exp = (rx_cnt == CNT_ONE);

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      IDLE:  if (!tx_empty) begin tx_pop = 1'b1; tx_next = START; end
      START: if (tx_exp) tx_next = DATA;
      DATA:  if (tx_exp && tx_bit == 3'd7) tx_next = STOP;
      STOP:  if (tx_exp) begin
               if (!tx_empty) begin tx_pop = 1'b1; tx_next = START; end
               else tx_next = IDLE;
             end
      default: tx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_state <= IDLE;
    else      tx_state <= tx_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt   <= BIT_LEN;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      uart_tx <= (tx_state == START) ? 1'b0 : (tx_state == DATA) ? tx_shift[0] : 1'b1;
      if (tx_pop) begin
        tx_shift <= tx_head;
        tx_cnt   <= BIT_LEN;
        tx_bit   <= '0;
      end else if (tx_state != IDLE) begin
        if (tx_exp) begin
          tx_cnt <= BIT_LEN;
          if (tx_state == DATA) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
          end
        end else begin
          tx_cnt <= tx_cnt - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    rx_next = rx_state;
    rx_push = 1'b0;
    case (rx_state)
      IDLE:  if (!rx_s) rx_next = START;
      START: if (rx_exp) rx_next = rx_s ? IDLE : DATA;
      DATA:  if (rx_exp && rx_bit == 3'd7) rx_next = STOP;
      STOP:  if (rx_exp) begin rx_next = IDLE; rx_push = rx_s; end
      default: rx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= IDLE;
    else      rx_state <= rx_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt   <= HALF_LEN;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (rx_state == IDLE) begin
      rx_cnt <= HALF_LEN;
      rx_bit <= '0;
    end else if (rx_exp) begin
      rx_cnt <= BIT_LEN;
      if (rx_state == DATA) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end else begin
      rx_cnt <= rx_cnt - CNT_ONE;
    end
  end
endmodule

// File: tb/tb_uart_mmio.sv
// Directed/randomized bench for uart_mmio: serial streams and register reads
// are predicted from byte queues and frame arithmetic.
module tb_uart_mmio;
  localparam int CLKDIV = 4;
  localparam int DEPTH  = 4;
  localparam int FRAME  = 10 * CLKDIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [1:0]  req_addr;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        uart_tx;
  logic        uart_rx;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] rx_q[$];

  uart_mmio #(.CLKDIV(CLKDIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_we(req_we), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Line level j cycles after the write edge: idle for 2 cycles, then back-to-back frames.
  function automatic logic line_at(input int j);
    int s, fr, b;
    if (j < 2) return 1'b1;
    s  = j - 2;
    fr = s / FRAME;
    if (fr >= exp_tx.size()) return 1'b1;
    b = (s % FRAME) / CLKDIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return exp_tx[fr][b-1];
  endfunction

  task automatic access(input logic we, input logic [1:0] addr, input logic [3:0] mask,
                        input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wmask = mask; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    check("resp_valid", 32'(resp_valid), 32'd1);
    rd = resp_rdata;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    access(1'b0, addr, 4'h0, 32'h0, rd);
    check(tag, rd, exp);
  endtask

  task automatic write_chk(input logic [1:0] addr, input logic [3:0] mask, input logic [31:0] wd);
    logic [31:0] rd;
    access(1'b1, addr, mask, wd, rd);
    check("wr_rdata", rd, 32'd0);
  endtask

  task automatic check_stream(input string tag, input int j0, input int jend);
    for (int j = j0; j <= jend; j++) begin
      @(negedge clk);
      check(tag, 32'(uart_tx), 32'(line_at(j)));
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      uart_rx = f[k];
      repeat (CLKDIV - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rx = 1'b1;
    if (stop && rx_q.size() < DEPTH) rx_q.push_back(b);
    repeat (2 * CLKDIV) @(negedge clk);
  endtask

  function automatic logic [31:0] rx_stat();
    return 32'h4 | ((rx_q.size() == DEPTH) ? 32'h2 : 32'h0) | ((rx_q.size() == 0) ? 32'h1 : 32'h0);
  endfunction

  task automatic drain_rx(input int n);
    logic [31:0] exp;
    for (int i = 0; i < n; i++) begin
      exp = (rx_q.size() > 0) ? {24'b0, rx_q.pop_front()} : 32'd0;
      read_chk("rx_read", 2'd1, exp);
    end
  endtask

  initial begin
    int fifo_cnt;
    logic busy;
    logic [7:0] b;

    rst = 1'b0; uart_rx = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wmask = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    read_chk("stat_reset", 2'd0, 32'h5);
    check("idle_tx", 32'(uart_tx), 32'd1);
    read_chk("rx_empty_read", 2'd1, 32'd0);
    read_chk("reserved_read", 2'd3, 32'd0);
    write_chk(2'd0, 4'hf, 32'hffff_ffff);
    @(negedge clk);
    check("resp_idle", 32'(resp_valid), 32'd0);

    // TX write with byte-0 disabled must not start a frame
    exp_tx.delete();
    write_chk(2'd2, 4'b1110, 32'h77);
    check_stream("tx_masked", 1, 3 * CLKDIV);
    read_chk("stat_masked", 2'd0, 32'h5);

    // Single frames: fixed pattern then random bytes
    for (int t = 0; t < 3; t++) begin
      b = (t == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      exp_tx.delete();
      exp_tx.push_back(b);
      write_chk(2'd2, 4'h1, {24'hABCDEF, b});
      check_stream("tx_single", 1, 2 + FRAME + 2);
      read_chk("stat_after_tx", 2'd0, 32'h5);
    end

    // Burst of 6 writes: one goes to the shifter, DEPTH are buffered, the rest drop
    exp_tx.delete();
    fifo_cnt = 0; busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("burst_resp", 32'(resp_valid), 32'd1);
        check("burst_line", 32'(uart_tx), 32'(line_at(i - 1)));
      end
      req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd2; req_wmask = 4'hf; req_wdata = 32'(i + 1);
      if (i >= 1 && !busy && fifo_cnt > 0) begin fifo_cnt--; busy = 1'b1; end
      if (fifo_cnt < DEPTH) begin fifo_cnt++; exp_tx.push_back(8'(i + 1)); end
    end
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    check("burst_resp", 32'(resp_valid), 32'd1);
    check("burst_line", 32'(uart_tx), 32'(line_at(5)));
    fork
      check_stream("tx_burst", 6, 2 + 5 * FRAME + 4);
      read_chk("stat_txfull", 2'd0, (fifo_cnt == DEPTH) ? 32'h9 : 32'h1);
    join
    read_chk("stat_burst_done", 2'd0, 32'h5);

    // RX: fill past capacity, then drain
    rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h11 + 8'(i), 1'b1);
      read_chk("rx_stat", 2'd0, rx_stat());
    end
    drain_rx(5);
    for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    read_chk("rx_stat_rand", 2'd0, rx_stat());
    drain_rx(4);

    // Glitch and framing error leave the RX FIFO empty; receiver still recovers
    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk); uart_rx = 1'b1;
    repeat (3 * CLKDIV) @(negedge clk);
    read_chk("stat_glitch", 2'd0, 32'h5);
    send_frame(8'($urandom_range(0, 255)), 1'b0);
    read_chk("stat_framing", 2'd0, 32'h5);
    read_chk("rx_framing", 2'd1, 32'd0);
    send_frame(8'h3C, 1'b1);
    drain_rx(1);

    // Reset in the middle of a data bit of a zero byte
    exp_tx.delete();
    exp_tx.push_back(8'h00);
    write_chk(2'd2, 4'h1, 32'h00);
    write_chk(2'd2, 4'h1, 32'h5A);
    write_chk(2'd2, 4'h1, 32'h3C);
    repeat (8) @(negedge clk);
    check("pre_reset_line", 32'(uart_tx), 32'(line_at(10)));
    #2 rst = 1'b0;
    #1 check("reset_tx_high", 32'(uart_tx), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    exp_tx.delete();
    check_stream("post_reset_idle", 1, 2 * FRAME);
    read_chk("stat_post_reset", 2'd0, 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
